// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target responder.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_slv_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and emits registered edge and START/STOP pulses.
// sda_s is delayed to line up with the event pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_rise_r;
  logic                   scl_fall_r;
  logic                   start_det_r;
  logic                   stop_det_r;
  logic                   scl_now_s;
  logic                   sda_now_s;

  assign scl_now_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_now_s = sda_sync_r[SYNC_STAGES-1];

  // Synchronizer chains, previous-value flops and registered bus events
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_r  <= {SYNC_STAGES{1'b1}};
      sda_sync_r  <= {SYNC_STAGES{1'b1}};
      scl_prev_r  <= 1'b1;
      sda_prev_r  <= 1'b1;
      scl_rise_r  <= 1'b0;
      scl_fall_r  <= 1'b0;
      start_det_r <= 1'b0;
      stop_det_r  <= 1'b0;
    end else begin
      scl_sync_r  <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r  <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
      scl_prev_r  <= scl_now_s;
      sda_prev_r  <= sda_now_s;
      scl_rise_r  <= scl_now_s & ~scl_prev_r;
      scl_fall_r  <= ~scl_now_s & scl_prev_r;
      start_det_r <= scl_now_s & scl_prev_r & sda_prev_r & ~sda_now_s;
      stop_det_r  <= scl_now_s & scl_prev_r & ~sda_prev_r & sda_now_s;
    end
  end

  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign sda_s     = sda_prev_r;
  assign start_det = start_det_r;
  assign stop_det  = stop_det_r;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target at one 7-bit address: captures write bytes, shifts out read bytes,
// drives SDA open-drain (sda_o only pulls low or releases).
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       rw,
  output logic       busy
);

  logic scl_rise_s, scl_fall_s, sda_s, start_det_s, stop_det_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .sda_s     (sda_s),
    .start_det (start_det_s),
    .stop_det  (stop_det_s)
  );

  i2c_slv_state_t state_r, nxt_state_s;
  logic [2:0] bit_cnt_r, nxt_bit_cnt_s;
  logic [7:0] shift_r, nxt_shift_s;
  logic       byte_done_r, nxt_byte_done_s;
  logic       sda_o_r, nxt_sda_o_s;
  logic [7:0] rx_data_r, nxt_rx_data_s;
  logic       rx_valid_r, nxt_rx_valid_s;
  logic       tx_req_r, nxt_tx_req_s;
  logic       rw_r, nxt_rw_s;
  logic       busy_r, nxt_busy_s;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      byte_done_r <= 1'b0;
      sda_o_r     <= 1'b1;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      tx_req_r    <= 1'b0;
      rw_r        <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      bit_cnt_r   <= nxt_bit_cnt_s;
      shift_r     <= nxt_shift_s;
      byte_done_r <= nxt_byte_done_s;
      sda_o_r     <= nxt_sda_o_s;
      rx_data_r   <= nxt_rx_data_s;
      rx_valid_r  <= nxt_rx_valid_s;
      tx_req_r    <= nxt_tx_req_s;
      rw_r        <= nxt_rw_s;
      busy_r      <= nxt_busy_s;
    end
  end

  // Next-state and output decode; tx_data loads while the registered tx_req is high
  always_comb begin
    nxt_state_s     = state_r;
    nxt_bit_cnt_s   = bit_cnt_r;
    nxt_shift_s     = tx_req_r ? tx_data : shift_r;
    nxt_byte_done_s = byte_done_r;
    nxt_sda_o_s     = sda_o_r;
    nxt_rx_data_s   = rx_data_r;
    nxt_rx_valid_s  = 1'b0;
    nxt_tx_req_s    = 1'b0;
    nxt_rw_s        = rw_r;
    nxt_busy_s      = busy_r;
    if (stop_det_s) begin
      nxt_state_s     = IDLE;
      nxt_bit_cnt_s   = 3'd0;
      nxt_byte_done_s = 1'b0;
      nxt_sda_o_s     = 1'b1;
      nxt_busy_s      = 1'b0;
    end else if (start_det_s) begin
      nxt_state_s     = ADDR;
      nxt_bit_cnt_s   = 3'd0;
      nxt_byte_done_s = 1'b0;
      nxt_sda_o_s     = 1'b1;
      nxt_busy_s      = 1'b0;
    end else begin
      case (state_r)
        ADDR: begin
          if (scl_rise_s) begin
            nxt_shift_s     = {shift_r[6:0], sda_s};
            nxt_bit_cnt_s   = bit_cnt_r + 3'd1;
            nxt_byte_done_s = (bit_cnt_r == 3'd7);
          end else if (scl_fall_s && byte_done_r) begin
            nxt_bit_cnt_s   = 3'd0;
            nxt_byte_done_s = 1'b0;
            if (shift_r[7:1] == SLAVE_ADDR) begin
              nxt_state_s  = ADDR_ACK;
              nxt_sda_o_s  = I2C_ACK;
              nxt_rw_s     = shift_r[0];
              nxt_busy_s   = 1'b1;
              nxt_tx_req_s = (shift_r[0] == I2C_RW_READ);
            end else begin
              nxt_state_s  = IGNORE;
            end
          end else begin
            nxt_state_s = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            nxt_bit_cnt_s = 3'd0;
            if (rw_r == I2C_RW_READ) begin
              nxt_state_s = RD_DATA;
              nxt_sda_o_s = shift_r[7];
            end else begin
              nxt_state_s = WR_DATA;
              nxt_sda_o_s = 1'b1;
            end
          end else begin
            nxt_state_s = ADDR_ACK;
          end
        end
        WR_DATA: begin
          if (scl_rise_s) begin
            nxt_shift_s   = {shift_r[6:0], sda_s};
            nxt_bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              nxt_byte_done_s = 1'b1;
              nxt_rx_data_s   = {shift_r[6:0], sda_s};
              nxt_rx_valid_s  = 1'b1;
            end else begin
              nxt_byte_done_s = 1'b0;
            end
          end else if (scl_fall_s && byte_done_r) begin
            nxt_state_s     = WR_ACK;
            nxt_sda_o_s     = I2C_ACK;
            nxt_byte_done_s = 1'b0;
            nxt_bit_cnt_s   = 3'd0;
          end else begin
            nxt_state_s = WR_DATA;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            nxt_state_s   = WR_DATA;
            nxt_sda_o_s   = 1'b1;
            nxt_bit_cnt_s = 3'd0;
          end else begin
            nxt_state_s = WR_ACK;
          end
        end
        RD_DATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_r == 3'd7) begin
              nxt_state_s   = RD_ACK;
              nxt_sda_o_s   = 1'b1;
              nxt_bit_cnt_s = 3'd0;
            end else begin
              nxt_shift_s   = {shift_r[6:0], 1'b0};
              nxt_sda_o_s   = shift_r[6];
              nxt_bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            nxt_state_s = RD_DATA;
          end
        end
        RD_ACK: begin
          if (scl_rise_s) begin
            if (sda_s == I2C_ACK) begin
              nxt_tx_req_s    = 1'b1;
              nxt_byte_done_s = 1'b1;
            end else begin
              nxt_state_s = IGNORE;
              nxt_busy_s  = 1'b0;
            end
          end else if (scl_fall_s && byte_done_r) begin
            nxt_state_s     = RD_DATA;
            nxt_sda_o_s     = shift_r[7];
            nxt_bit_cnt_s   = 3'd0;
            nxt_byte_done_s = 1'b0;
          end else begin
            nxt_state_s = RD_ACK;
          end
        end
        IDLE, IGNORE: begin
          nxt_sda_o_s = 1'b1;
        end
        default: begin
          nxt_state_s = IDLE;
          nxt_sda_o_s = 1'b1;
          nxt_busy_s  = 1'b0;
        end
      endcase
    end
  end

  assign sda_o    = sda_o_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign tx_req   = tx_req_r;
  assign rw       = rw_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a bit-banged I2C master on an open-drain SDA wire drives the target.
module tb_i2c_slave_responder;

  localparam int T = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_o, rx_valid, tx_req, rw, busy;
  logic [7:0] rx_data;
  wire        sda_bus = sda_m & sda_o;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, tx_cnt = 0, overlap_cnt = 0, sda_low_cnt = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_o    (sda_o),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .rw       (rw),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (tx_req) tx_cnt++;
    if (rx_valid && tx_req) overlap_cnt++;
    if (!sda_o) sda_low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T);
    r = sda_bus;
    wait_clk(T);
    scl_m = 1'b0;
    wait_clk(T);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T);
    sda_m = 1'b0;
    wait_clk(T);
    scl_m = 1'b0;
    wait_clk(T);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T);
    sda_m = 1'b1;
    wait_clk(2 * T);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      v[i] = r;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    checks += 6;
    if (sda_o !== 1'b1) begin errors++; $display("FAIL reset_sda_o: got %b want 1", sda_o); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", rw); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic a;
    int rx0 = rx_cnt;
    bus_start();
    send_byte(8'hAA);
    clock_bit(1'b1, a);
    checks += 3;
    if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", a); end
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
    if (rw !== 1'b0) begin errors++; $display("FAIL wr_rw: got %b want 0", rw); end
    send_byte(8'hAA);
    clock_bit(1'b1, a);
    bus_stop();
    checks += 4;
    if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b want 0", a); end
    if (rx_data !== 8'hAA) begin errors++; $display("FAIL wr_rx_data: got %h want aa", rx_data); end
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL wr_rx_valid_count: got %0d want 1", rx_cnt - rx0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] v;
    int tx0 = tx_cnt;
    tx_data = 8'h01;
    bus_start();
    send_byte(8'hAB);
    clock_bit(1'b1, a);
    checks += 3;
    if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    if (rw !== 1'b1) begin errors++; $display("FAIL rd_rw: got %b want 1", rw); end
    if (tx_cnt - tx0 != 1) begin errors++; $display("FAIL rd_tx_req_count: got %0d want 1", tx_cnt - tx0); end
    read_byte(v);
    clock_bit(1'b1, a);
    checks += 3;
    if (v !== 8'h01) begin errors++; $display("FAIL rd_byte: got %h want 01", v); end
    if (sda_o !== 1'b1) begin errors++; $display("FAIL rd_nack_sda_o: got %b want 1", sda_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy: got %b want 0", busy); end
    bus_stop();
  endtask

  task automatic test_no_match();
    logic a1, a2;
    int rx0 = rx_cnt, low0 = sda_low_cnt, b0 = busy_cnt;
    bus_start();
    send_byte(8'h46);
    clock_bit(1'b1, a1);
    send_byte(8'h5A);
    clock_bit(1'b1, a2);
    bus_stop();
    checks += 5;
    if (a1 !== 1'b1) begin errors++; $display("FAIL nm_addr_nack: got %b want 1", a1); end
    if (a2 !== 1'b1) begin errors++; $display("FAIL nm_data_nack: got %b want 1", a2); end
    if (sda_low_cnt != low0) begin errors++; $display("FAIL nm_sda_low_cycles: got %0d want 0", sda_low_cnt - low0); end
    if (rx_cnt != rx0) begin errors++; $display("FAIL nm_rx_valid_count: got %0d want 0", rx_cnt - rx0); end
    if (busy_cnt != b0) begin errors++; $display("FAIL nm_busy_cycles: got %0d want 0", busy_cnt - b0); end
  endtask

  task automatic test_back_to_back_read();
    logic a;
    logic [7:0] v1, v2;
    int tx0 = tx_cnt;
    tx_data = 8'h3C;
    bus_start();
    send_byte(8'hAB);
    clock_bit(1'b1, a);
    tx_data = 8'hC3;
    read_byte(v1);
    clock_bit(1'b0, a);
    read_byte(v2);
    clock_bit(1'b1, a);
    checks += 4;
    if (v1 !== 8'h3C) begin errors++; $display("FAIL rd2_byte0: got %h want 3c", v1); end
    if (v2 !== 8'hC3) begin errors++; $display("FAIL rd2_byte1: got %h want c3", v2); end
    if (sda_o !== 1'b1) begin errors++; $display("FAIL rd2_nack_sda_o: got %b want 1", sda_o); end
    if (tx_cnt - tx0 != 2) begin errors++; $display("FAIL rd2_tx_req_count: got %0d want 2", tx_cnt - tx0); end
    bus_stop();
  endtask

  task automatic test_restart();
    logic a;
    logic [7:0] v;
    int rx0 = rx_cnt;
    tx_data = 8'h96;
    bus_start();
    send_byte(8'hAA);
    clock_bit(1'b1, a);
    clock_bit(1'b1, a);
    clock_bit(1'b0, a);
    clock_bit(1'b1, a);
    clock_bit(1'b0, a);
    bus_start();
    send_byte(8'hAB);
    clock_bit(1'b1, a);
    checks += 2;
    if (a !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b want 0", a); end
    if (rw !== 1'b1) begin errors++; $display("FAIL rs_rw: got %b want 1", rw); end
    read_byte(v);
    clock_bit(1'b1, a);
    bus_stop();
    checks += 2;
    if (v !== 8'h96) begin errors++; $display("FAIL rs_byte: got %h want 96", v); end
    if (rx_cnt != rx0) begin errors++; $display("FAIL rs_rx_valid_count: got %0d want 0", rx_cnt - rx0); end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    int rx0;
    tx_data = 8'h0F;
    bus_start();
    send_byte(8'hAB);
    clock_bit(1'b1, a);
    checks += 2;
    if (a !== 1'b0) begin errors++; $display("FAIL mr_addr_ack: got %b want 0", a); end
    if (sda_o !== 1'b0) begin errors++; $display("FAIL mr_driving_zero: got %b want 0", sda_o); end
    reset = 1'b1;
    wait_clk(1);
    checks += 2;
    if (sda_o !== 1'b1) begin errors++; $display("FAIL mr_reset_sda_o: got %b want 1", sda_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mr_reset_busy: got %b want 0", busy); end
    wait_clk(2);
    reset = 1'b0;
    sda_m = 1'b1;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(2 * T);
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'hAA);
    clock_bit(1'b1, a);
    checks += 1;
    if (a !== 1'b0) begin errors++; $display("FAIL mr_readdr_ack: got %b want 0", a); end
    send_byte(8'h11);
    clock_bit(1'b1, a);
    bus_stop();
    checks += 3;
    if (a !== 1'b0) begin errors++; $display("FAIL mr_data_ack: got %b want 0", a); end
    if (rx_data !== 8'h11) begin errors++; $display("FAIL mr_rx_data: got %h want 11", rx_data); end
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL mr_rx_valid_count: got %0d want 1", rx_cnt - rx0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_match();
    test_back_to_back_read();
    test_restart();
    test_reset_mid_read();
    checks += 1;
    if (overlap_cnt != 0) begin errors++; $display("FAIL tx_rx_overlap: got %0d want 0", overlap_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
